free_list: RTL and testbench
============================

Name: free_list

Overview:
- Circular FIFO of free physical register tags for the rename stage, sitting directly upstream of the RAT.
- Supplies the new destination tag for each renamed instruction (feeds the RAT's rd_new_tag).
- Accepts tags released at ROB commit (the committing instruction's rd_old_tag).
- One allocate port and one free port per cycle.

Parameters:
- ARCH_REGS, default N_ARCH_REGS (32): architectural register count; tags 0..ARCH_REGS-1 are mapped at reset.
- PHYS_REGS, default N_PHYS_REGS (64): physical register count.
- TAG_W, default PREG_W (6): tag width, equal to clog2(PHYS_REGS).
- DEPTH, default PHYS_REGS-ARCH_REGS (32): FIFO entries.
- CNT_W, default clog2(DEPTH)+1 (6): width of the count field.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- alloc_req  input  1  rename requests one tag this cycle
- alloc_valid  output  1  a free tag is available (count != 0)
- alloc_tag  output  TAG_W  tag at head; valid when alloc_valid
- free_we  input  1  release free_tag this cycle
- free_tag  input  TAG_W  tag being returned
- free_count  output  CNT_W  number of tags currently in list
- full  output  1  free_count == DEPTH
- free_err  output  1  illegal-free flag; see Optional Feature

Behaviour:
- Storage: DEPTH x TAG_W array, head pointer, tail pointer (each 0..DEPTH-1), and count (0..DEPTH).
- Reset (async, rst=1):
  - entry[i] = ARCH_REGS+i for all i.
  - head=0, tail=0, count=DEPTH.
  - Outputs: alloc_valid=1, alloc_tag=ARCH_REGS (32), full=1, free_count=DEPTH, free_err=0.
- alloc_valid and alloc_tag are combinational from head and count, with zero-latency lookahead.
- Allocate fires when alloc_req && alloc_valid. On that clock edge head advances by 1, wrapping DEPTH-1 -> 0.
  - alloc_req with alloc_valid=0 is a no-op. Rename must stall and re-present the request.
- Free accept:
  - Accepted when free_we && free_tag != 0 && !(count==DEPTH && !alloc_fire).
  - On that edge: entry[tail] <= free_tag, tail advances by 1 with wrap.
  - free_tag == 0 is silently dropped; x0 stays permanently mapped.
- Count update: +1 on free only, -1 on alloc only, unchanged on both or neither.
- Alloc and free in the same cycle:
  - Both take effect; count is unchanged.
  - Legal even when full, because the slot vacated at head is reused.
- Free while empty: the freed tag is not bypassed. alloc_valid rises the next cycle, with alloc_tag = free_tag.
- Free while full without an alloc in the same cycle: the free is dropped and the list is unchanged. This is a protocol violation.
- Pointer wrap: head and tail wrap independently. Ordering is strict FIFO.
- rst asserted mid-operation restores the reset image immediately, discarding all in-flight frees and allocations.
- No flush/recovery port. Misprediction recovery is outside this block.

Optional Feature:
- Macro: FREE_LIST_CHECK_EN.
- With the macro defined, the block keeps a PHYS_REGS-bit in_list vector:
  - Reset value: bits ARCH_REGS..PHYS_REGS-1 set, all others clear.
  - An accepted alloc clears bit[alloc_tag]; an accepted free sets bit[free_tag].
- free_err is registered and pulses high for one cycle after a free_we cycle where any of these holds:
  - free_tag == 0.
  - bit[free_tag] is already set (double free).
  - The free is dropped because the list is full.
- Other than that, an erroneous free behaves as in Behaviour.
- Without the macro: no in_list vector, and free_err is tied to 0.

Test Plan:
- Reset, then 32 consecutive alloc_req -> alloc_tag sequence 32,33,...,63. After the 32nd, alloc_valid=0, free_count=0, full=0.
- From empty, free_we with free_tag=7 -> alloc_valid=0 in the same cycle. Next cycle alloc_valid=1, alloc_tag=7, free_count=1.
- While full after reset, free_tag=40 with no alloc -> dropped, free_count stays 32. With FREE_LIST_CHECK_EN, free_err=1 on the next cycle.
- While full, simultaneous alloc and free of tag 5 -> alloc_tag=32 consumed, count stays 32. Tag 5 appears after 31 further allocs (tags 33..63).
- Free tag 0 -> ignored, count unchanged. With FREE_LIST_CHECK_EN, free_err pulses; without it, free_err=0.
- Allocate 10, free 3, and assert rst mid-sequence -> immediately free_count=32, alloc_tag=32, free_err=0.

Source files
------------

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags feeding the RAT at rename.
// Optional macro FREE_LIST_CHECK_EN adds an in-list vector and a registered illegal-free flag.
module free_list #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int TAG_W     = $clog2(PHYS_REGS),
  parameter int DEPTH     = PHYS_REGS - ARCH_REGS,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_valid,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             free_we,
  input  logic [TAG_W-1:0] free_tag,
  output logic [CNT_W-1:0] free_count,
  output logic             full,
  output logic             free_err
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_alloc_fire;
  logic w_full_block;
  logic w_free_acc;

  assign w_full       = (r_count == CNT_FULL);
  assign alloc_valid  = (r_count != '0);
  assign alloc_tag    = r_mem[r_head];
  assign w_alloc_fire = alloc_req && alloc_valid;
  // A free into a full list only fits when the head slot is vacated this same cycle.
  assign w_full_block = w_full && !w_alloc_fire;
  assign w_free_acc   = free_we && (free_tag != '0) && !w_full_block;

  assign free_count = r_count;
  assign full       = w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= TAG_W'(ARCH_REGS + i);
      end
    end else if (w_free_acc) begin
      r_mem[r_tail] <= free_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_FULL;
    end else begin
      if (w_alloc_fire) begin
        r_head <= (r_head == PTR_LAST) ? '0 : r_head + 1'b1;
      end
      if (w_free_acc) begin
        r_tail <= (r_tail == PTR_LAST) ? '0 : r_tail + 1'b1;
      end
      unique case ({w_alloc_fire, w_free_acc})
        2'b10:   r_count <= r_count - 1'b1;
        2'b01:   r_count <= r_count + 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic [PHYS_REGS-1:0] r_in_list;
  logic                 r_free_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        r_in_list[i] <= (i >= ARCH_REGS);
      end
      r_free_err <= 1'b0;
    end else begin
      if (w_alloc_fire) begin
        r_in_list[alloc_tag] <= 1'b0;
      end
      if (w_free_acc) begin
        r_in_list[free_tag] <= 1'b1;
      end
      r_free_err <= free_we && ((free_tag == '0) || r_in_list[free_tag] || w_full_block);
    end
  end

  assign free_err = r_free_err;
`else
  assign free_err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list (default parameters, either macro setting).
module tb_free_list;

`ifdef FREE_LIST_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req = 1'b0;
  logic       alloc_valid;
  logic [5:0] alloc_tag;
  logic       free_we = 1'b0;
  logic [5:0] free_tag = '0;
  logic [5:0] free_count;
  logic       full;
  logic       free_err;

  int n_checks = 0;
  int n_fail   = 0;

  free_list dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_req  (alloc_req),
    .alloc_valid(alloc_valid),
    .alloc_tag  (alloc_tag),
    .free_we    (free_we),
    .free_tag   (free_tag),
    .free_count (free_count),
    .full       (full),
    .free_err   (free_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_req = 1'b0; free_we = 1'b0; free_tag = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (alloc_valid !== 1'b1) begin n_fail++; $display("FAIL reset_valid got=%0b exp=1", alloc_valid); end
    n_checks++; if (alloc_tag !== 6'd32) begin n_fail++; $display("FAIL reset_tag got=%0d exp=32", alloc_tag); end
    n_checks++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL reset_count got=%0d exp=32", free_count); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL reset_full got=%0b exp=1", full); end
    n_checks++; if (free_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", free_err); end
  endtask

  task automatic test_alloc_drain();
    for (int i = 0; i < 32; i++) begin
      n_checks++; if (alloc_valid !== 1'b1 || alloc_tag !== 6'(32 + i)) begin
        n_fail++; $display("FAIL drain_tag[%0d] got=%0d/%0b exp=%0d/1", i, alloc_tag, alloc_valid, 32 + i);
      end
      alloc_req = 1'b1;
      step();
    end
    alloc_req = 1'b0;
    n_checks++; if (alloc_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%0b exp=0", alloc_valid); end
    n_checks++; if (free_count !== 6'd0) begin n_fail++; $display("FAIL drain_count got=%0d exp=0", free_count); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL drain_full got=%0b exp=0", full); end
    // alloc_req while empty must be a no-op
    alloc_req = 1'b1;
    step();
    alloc_req = 1'b0;
    n_checks++; if (free_count !== 6'd0) begin n_fail++; $display("FAIL empty_alloc_count got=%0d exp=0", free_count); end
  endtask

  task automatic test_free_empty();
    free_we = 1'b1; free_tag = 6'd7;
    #1;
    n_checks++; if (alloc_valid !== 1'b0) begin n_fail++; $display("FAIL empty_nobypass got=%0b exp=0", alloc_valid); end
    step();
    free_we = 1'b0; free_tag = '0;
    n_checks++; if (alloc_valid !== 1'b1) begin n_fail++; $display("FAIL empty_valid got=%0b exp=1", alloc_valid); end
    n_checks++; if (alloc_tag !== 6'd7) begin n_fail++; $display("FAIL empty_tag got=%0d exp=7", alloc_tag); end
    n_checks++; if (free_count !== 6'd1) begin n_fail++; $display("FAIL empty_count got=%0d exp=1", free_count); end
    n_checks++; if (free_err !== 1'b0) begin n_fail++; $display("FAIL empty_err got=%0b exp=0", free_err); end
  endtask

  task automatic test_full_drop();
    do_reset();
    free_we = 1'b1; free_tag = 6'd40;
    step();
    free_we = 1'b0; free_tag = '0;
    n_checks++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL drop_count got=%0d exp=32", free_count); end
    n_checks++; if (alloc_tag !== 6'd32) begin n_fail++; $display("FAIL drop_tag got=%0d exp=32", alloc_tag); end
    n_checks++; if (free_err !== CHK) begin n_fail++; $display("FAIL drop_err got=%0b exp=%0b", free_err, CHK); end
    step();
    n_checks++; if (free_err !== 1'b0) begin n_fail++; $display("FAIL drop_err_pulse got=%0b exp=0", free_err); end
  endtask

  task automatic test_simul_full();
    do_reset();
    alloc_req = 1'b1; free_we = 1'b1; free_tag = 6'd5;
    #1;
    n_checks++; if (alloc_tag !== 6'd32) begin n_fail++; $display("FAIL simul_tag got=%0d exp=32", alloc_tag); end
    step();
    alloc_req = 1'b0; free_we = 1'b0; free_tag = '0;
    n_checks++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL simul_count got=%0d exp=32", free_count); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL simul_full got=%0b exp=1", full); end
    n_checks++; if (free_err !== 1'b0) begin n_fail++; $display("FAIL simul_err got=%0b exp=0", free_err); end
    for (int i = 0; i < 31; i++) begin
      n_checks++; if (alloc_tag !== 6'(33 + i)) begin
        n_fail++; $display("FAIL simul_seq[%0d] got=%0d exp=%0d", i, alloc_tag, 33 + i);
      end
      alloc_req = 1'b1;
      step();
    end
    alloc_req = 1'b0;
    n_checks++; if (alloc_tag !== 6'd5) begin n_fail++; $display("FAIL simul_wrap_tag got=%0d exp=5", alloc_tag); end
    n_checks++; if (free_count !== 6'd1) begin n_fail++; $display("FAIL simul_wrap_count got=%0d exp=1", free_count); end
  endtask

  task automatic test_free_zero();
    free_we = 1'b1; free_tag = 6'd0;
    step();
    free_we = 1'b0;
    n_checks++; if (free_count !== 6'd1) begin n_fail++; $display("FAIL zero_count got=%0d exp=1", free_count); end
    n_checks++; if (alloc_tag !== 6'd5) begin n_fail++; $display("FAIL zero_tag got=%0d exp=5", alloc_tag); end
    n_checks++; if (free_err !== CHK) begin n_fail++; $display("FAIL zero_err got=%0b exp=%0b", free_err, CHK); end
  endtask

  task automatic test_back_to_back();
    // count=1 holding tag 5: alloc 5 while freeing 9, then alloc 9 while freeing 11
    alloc_req = 1'b1; free_we = 1'b1; free_tag = 6'd9;
    step();
    n_checks++; if (alloc_tag !== 6'd9 || free_count !== 6'd1) begin
      n_fail++; $display("FAIL b2b_first got=%0d/%0d exp=9/1", alloc_tag, free_count);
    end
    free_tag = 6'd11;
    step();
    alloc_req = 1'b0; free_we = 1'b0; free_tag = '0;
    n_checks++; if (alloc_tag !== 6'd11 || free_count !== 6'd1) begin
      n_fail++; $display("FAIL b2b_second got=%0d/%0d exp=11/1", alloc_tag, free_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_req = 1'b1;
    repeat (10) step();
    alloc_req = 1'b0;
    free_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      free_tag = 6'(33 + 2 * i);
      step();
    end
    free_we = 1'b0; free_tag = '0;
    n_checks++; if (free_count !== 6'd25) begin n_fail++; $display("FAIL mid_pre_count got=%0d exp=25", free_count); end
    n_checks++; if (alloc_tag !== 6'd42) begin n_fail++; $display("FAIL mid_pre_tag got=%0d exp=42", alloc_tag); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL mid_count got=%0d exp=32", free_count); end
    n_checks++; if (alloc_tag !== 6'd32) begin n_fail++; $display("FAIL mid_tag got=%0d exp=32", alloc_tag); end
    n_checks++; if (free_err !== 1'b0) begin n_fail++; $display("FAIL mid_err got=%0b exp=0", free_err); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL mid_full got=%0b exp=1", full); end
    step();
    rst = 1'b0;
    step();
    n_checks++; if (alloc_tag !== 6'd32 || free_count !== 6'd32) begin
      n_fail++; $display("FAIL mid_post got=%0d/%0d exp=32/32", alloc_tag, free_count);
    end
  endtask

  initial begin
    test_reset();
    test_alloc_drain();
    test_free_empty();
    test_full_drop();
    test_simul_full();
    test_free_zero();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
